// File: rtl/tluh_atomic_unit_if.sv
// Request/response bundle of the TL-UH atomic execution unit.
// The slave modport is the unit itself; the master modport is the adapter side driving it.
interface tluh_atomic_unit_if #(
  parameter int DW = 32
);
  logic          req_valid_i;
  logic          req_ready_o;
  logic [2:0]    req_opcode_i;
  logic [2:0]    req_param_i;
  logic [1:0]    req_size_i;
  logic [DW/8-1:0] req_mask_i;
  logic [DW-1:0] req_old_i;
  logic [DW-1:0] req_arg_i;
  logic          req_last_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [DW-1:0] rsp_data_o;
  logic [DW-1:0] rsp_old_o;
  logic          rsp_last_o;
  logic          rsp_err_o;

  modport slave (
    input  req_valid_i, req_opcode_i, req_param_i, req_size_i, req_mask_i,
    input  req_old_i, req_arg_i, req_last_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_old_o, rsp_last_o, rsp_err_o
  );

  modport master (
    output req_valid_i, req_opcode_i, req_param_i, req_size_i, req_mask_i,
    output req_old_i, req_arg_i, req_last_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_old_o, rsp_last_o, rsp_err_o
  );
endinterface

// File: rtl/tluh_atomic_unit.sv
// TL-UH atomic execution unit: arithmetic/logical atomics per lane with byte masks,
// burst context tracking and a single registered output stage.
module tluh_atomic_unit #(
  parameter int DW        = 32,
  parameter int MAX_BEATS = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  tluh_atomic_unit_if.slave bus
);
  localparam int NB = DW / 8;
  localparam int CW = $clog2(MAX_BEATS + 1);
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  // Lanes are worked in a 64-bit scratch; signed order is unsigned order with the lane sign bit flipped.
  function automatic logic [DW-1:0] f_lanes(input logic arith, input logic [2:0] param,
                                            input logic [1:0] size, input logic [DW-1:0] old_v,
                                            input logic [DW-1:0] arg_v);
    logic [63:0] v_old, v_arg, v_res, v_a, v_b, v_lm, v_sb, v_r;
    v_old = 64'(old_v);
    v_arg = 64'(arg_v);
    v_res = 64'd0;
    for (int sz = 0; sz < 4; sz++) begin
      if (2'(sz) == size) begin
        v_lm = (sz == 3) ? {64{1'b1}} : ((64'd1 << (8 << sz)) - 64'd1);
        v_sb = 64'd1 << ((8 << sz) - 1);
        for (int l = 0; l < DW / (8 << sz); l++) begin
          v_a = (v_old >> (l * (8 << sz))) & v_lm;
          v_b = (v_arg >> (l * (8 << sz))) & v_lm;
          if (arith) begin
            case (param)
              3'd0:    v_r = ((v_b ^ v_sb) < (v_a ^ v_sb)) ? v_b : v_a;
              3'd1:    v_r = ((v_b ^ v_sb) > (v_a ^ v_sb)) ? v_b : v_a;
              3'd2:    v_r = (v_b < v_a) ? v_b : v_a;
              3'd3:    v_r = (v_b > v_a) ? v_b : v_a;
              3'd4:    v_r = v_a + v_b;
              default: v_r = v_a;
            endcase
          end else begin
            case (param)
              3'd0:    v_r = v_a ^ v_b;
              3'd1:    v_r = v_a | v_b;
              3'd2:    v_r = v_a & v_b;
              3'd3:    v_r = v_b;
              default: v_r = v_a;
            endcase
          end
          v_res = v_res | ((v_r & v_lm) << (l * (8 << sz)));
        end
      end
    end
    return v_res[DW-1:0];
  endfunction

  logic [0:0]    r_state;
  logic [CW-1:0] r_count;
  logic [2:0]    r_op, r_param;
  logic [1:0]    r_size;
  logic          r_valid, r_last, r_err;
  logic [DW-1:0] r_data, r_old;

  logic          w_ready, w_fire, w_overrun, w_illegal, w_bad_size;
  logic [2:0]    w_op, w_param;
  logic [1:0]    w_size;
  logic [CW:0]   w_beat;
  logic [DW-1:0] w_lanes, w_merged, w_data;

  // Handshake, effective context, error detection and result data for the offered beat.
  always_comb begin
    w_ready    = !r_valid || bus.rsp_ready_i;
    w_fire     = bus.req_valid_i && w_ready;
    w_op       = bus.req_opcode_i;
    w_param    = bus.req_param_i;
    w_size     = bus.req_size_i;
    w_beat     = (CW+1)'(1);
    w_illegal  = 1'b1;
    w_merged   = bus.req_old_i;
    if (r_state == ST_BURST) begin
      w_op    = r_op;
      w_param = r_param;
      w_size  = r_size;
      w_beat  = (CW+1)'(r_count) + (CW+1)'(1);
    end else begin
      w_beat  = (CW+1)'(1);
    end
    w_overrun = (w_beat == (CW+1)'(MAX_BEATS)) && !bus.req_last_i;
    case (w_op)
      3'd2:    w_illegal = w_param > 3'd4;
      3'd3:    w_illegal = w_param > 3'd3;
      default: w_illegal = 1'b1;
    endcase
    w_bad_size = (32'd8 << w_size) > 32'(DW);
    w_lanes    = f_lanes(w_op == 3'd2, w_param, w_size, bus.req_old_i, bus.req_arg_i);
    for (int b = 0; b < NB; b++) begin
      w_merged[8*b +: 8] = bus.req_mask_i[b] ? w_lanes[8*b +: 8] : bus.req_old_i[8*b +: 8];
    end
    if (w_illegal || w_bad_size) begin
      w_data = bus.req_old_i;
    end else begin
      w_data = w_merged;
    end
  end

  // Burst FSM: the first beat latches the context, last or overrun returns to IDLE.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_op    <= 3'd0;
      r_param <= 3'd0;
      r_size  <= 2'd0;
    end else if (w_fire) begin
      if (r_state == ST_IDLE) begin
        r_op    <= bus.req_opcode_i;
        r_param <= bus.req_param_i;
        r_size  <= bus.req_size_i;
      end else begin
        r_op    <= r_op;
        r_param <= r_param;
        r_size  <= r_size;
      end
      if (bus.req_last_i || w_overrun) begin
        r_state <= ST_IDLE;
        r_count <= '0;
      end else begin
        r_state <= ST_BURST;
        r_count <= w_beat[CW-1:0];
      end
    end else begin
      r_state <= r_state;
      r_count <= r_count;
    end
  end

  // Output register: loads on every accepted beat, otherwise drains or holds.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_old   <= '0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
    end else if (w_fire) begin
      r_valid <= 1'b1;
      r_data  <= w_data;
      r_old   <= bus.req_old_i;
      r_last  <= bus.req_last_i || w_overrun;
      r_err   <= w_illegal || w_bad_size || w_overrun;
    end else if (bus.rsp_ready_i) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

  assign bus.req_ready_o = w_ready;
  assign bus.rsp_valid_o = r_valid;
  assign bus.rsp_data_o  = r_data;
  assign bus.rsp_old_o   = r_old;
  assign bus.rsp_last_o  = r_last;
  assign bus.rsp_err_o   = r_err;
endmodule
